// File: rtl/rtr_ftc_pkg.sv
// rtr_ftc_pkg: shared error codes, per-VC FSM states and width helpers for the flit type checker
package rtr_ftc_pkg;
   typedef enum logic [2:0] {
      ERR_NONE        = 3'd0,
      ERR_BAD_VC      = 3'd1,
      ERR_NO_HEAD     = 3'd2,
      ERR_HEAD_IN_PKT = 3'd3,
      ERR_LONG        = 3'd4,
      ERR_SHORT       = 3'd5
   } err_code_e;
   typedef enum logic {ST_IDLE, ST_PKT} vc_state_e;
   localparam int code_w = 3;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic int vc_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction
endpackage

// File: rtl/rtr_ftc_vc_tracker.sv
// rtr_ftc_vc_tracker: head/body/tail ordering and length tracking for a single VC
module rtr_ftc_vc_tracker
   import rtr_ftc_pkg::*;
#(
   parameter int min_flits = 1,
   parameter int max_flits = 8,
   localparam int cw = clog2(max_flits + 2)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sel,
   input  logic              upd,
   input  logic              head,
   input  logic              tail,
   output logic [code_w-1:0] code
);
   localparam logic [cw:0]   n_max = (cw + 1)'(max_flits);
   localparam logic [cw:0]   n_lim = (cw + 1)'(max_flits + 1);
   localparam logic [cw:0]   n_min = (cw + 1)'(min_flits);
   localparam logic [cw-1:0] c_lim = cw'(max_flits + 1);
   localparam logic [cw-1:0] c_one = cw'(1);
   localparam bit            one_short = min_flits > 1;
   vc_state_e     state, state_nx;
   logic [cw-1:0] cnt, cnt_nx;
   logic          long_seen, long_nx;
   logic [cw:0]   n;
   assign n = {1'b0, cnt} + (cw + 1)'(1);
   // classify the current flit and derive next per-VC state
   always_comb begin
      code     = ERR_NONE;
      state_nx = state;
      cnt_nx   = cnt;
      long_nx  = long_seen;
      if (sel && head) begin
         code     = (state == ST_PKT) ? ERR_HEAD_IN_PKT : (tail && one_short) ? ERR_SHORT : ERR_NONE;
         state_nx = tail ? ST_IDLE : ST_PKT;
         cnt_nx   = tail ? '0 : c_one;
         long_nx  = 1'b0;
      end else if (sel && state == ST_IDLE) begin
         code = ERR_NO_HEAD;
      end else if (sel && tail) begin
         code     = (n > n_max && !long_seen) ? ERR_LONG : (n < n_min) ? ERR_SHORT : ERR_NONE;
         state_nx = ST_IDLE;
         cnt_nx   = '0;
         long_nx  = 1'b0;
      end else if (sel) begin
         code    = (n == n_lim && !long_seen) ? ERR_LONG : ERR_NONE;
         cnt_nx  = (n > n_lim) ? c_lim : n[cw-1:0];
         long_nx = long_seen | (n == n_lim);
      end
   end
   // per-VC state register, frozen unless this VC owns an accepted flit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         long_seen <= 1'b0;
      end else if (upd) begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         long_seen <= long_nx;
      end
   end
endmodule

// File: rtl/rtr_vc_flit_type_check.sv
// rtr_vc_flit_type_check: per-VC flit framing monitor with sticky first-error capture; RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN adds error_count
module rtr_vc_flit_type_check
   import rtr_ftc_pkg::*;
#(
   parameter int num_vcs     = 4,
   parameter int min_flits   = 1,
   parameter int max_flits   = 8,
   parameter int count_width = 16,
   localparam int vw = vc_w(num_vcs)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   active,
   input  logic                   flit_valid,
   input  logic                   flit_head,
   input  logic                   flit_tail,
   input  logic [num_vcs-1:0]     flit_sel_ovc,
   input  logic                   error_clear,
`ifdef RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN
   output logic [count_width-1:0] error_count,
`endif
   output logic                   error,
   output logic [code_w-1:0]      error_code,
   output logic [vw-1:0]          error_vc,
   output logic [num_vcs-1:0]     sticky_error,
   output logic [code_w-1:0]      first_error_code,
   output logic [vw-1:0]          first_error_vc
);
   logic              onehot;
   logic [code_w-1:0] vc_code [num_vcs];
   logic [code_w-1:0] or_code;
   logic [vw-1:0]     idx;
   err_code_e         ecode;
   assign onehot = (|flit_sel_ovc) && ~|(flit_sel_ovc & (flit_sel_ovc - num_vcs'(1)));
   for (genvar i = 0; i < num_vcs; i++) begin : g_vc
      logic sel;
      assign sel = flit_valid && onehot && flit_sel_ovc[i];
      rtr_ftc_vc_tracker #(.min_flits(min_flits), .max_flits(max_flits)) u_trk (
         .clk   (clk),
         .reset (reset),
         .sel   (sel),
         .upd   (sel && active),
         .head  (flit_head),
         .tail  (flit_tail),
         .code  (vc_code[i])
      );
   end
   // only the selected tracker reports a code, so OR-reduce them and encode the VC index
   always_comb begin
      or_code = '0;
      idx     = '0;
      for (int i = 0; i < num_vcs; i++) begin
         or_code = or_code | vc_code[i];
         if (flit_sel_ovc[i]) idx = vw'(i);
      end
      ecode      = !flit_valid ? ERR_NONE : !onehot ? ERR_BAD_VC : err_code_e'(or_code);
      error      = ecode != ERR_NONE;
      error_code = ecode;
      error_vc   = (error && onehot) ? idx : '0;
   end
   // sticky bits and first-error capture; a new error beats a simultaneous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sticky_error     <= '0;
         first_error_code <= ERR_NONE;
         first_error_vc   <= '0;
      end else if (active) begin
         sticky_error <= (error_clear ? '0 : sticky_error) | ((error && onehot) ? flit_sel_ovc : '0);
         if (error && (error_clear || first_error_code == ERR_NONE)) begin
            first_error_code <= error_code;
            first_error_vc   <= error_vc;
         end else if (error_clear) begin
            first_error_code <= ERR_NONE;
            first_error_vc   <= '0;
         end
      end
   end
`ifdef RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN
   logic [count_width-1:0] cnt_base;
   assign cnt_base = error_clear ? '0 : error_count;
   // saturating error counter, restarts from the clear value when cleared
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) error_count <= '0;
      else if (active && (error || error_clear)) error_count <= (error && ~&cnt_base) ? cnt_base + count_width'(1) : cnt_base;
   end
`endif
`ifndef SYNTHESIS
   // simulation-only error trace
   always @(posedge clk) begin
      if (reset && error) $display("%m: flit error %s on vc %0d", ecode.name(), error_vc);
   end
`endif
endmodule

// File: tb/tb_rtr_vc_flit_type_check.sv
// tb_rtr_vc_flit_type_check: table-driven directed check of the per-VC flit type checker
module tb_rtr_vc_flit_type_check;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       active = 1'b1;
   logic       flit_valid = 1'b0;
   logic       flit_head = 1'b0;
   logic       flit_tail = 1'b0;
   logic [3:0] flit_sel_ovc = '0;
   logic       error_clear = 1'b0;
   logic       error;
   logic [2:0] error_code;
   logic [1:0] error_vc;
   logic [3:0] sticky_error;
   logic [2:0] first_error_code;
   logic [1:0] first_error_vc;
`ifdef RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN
   logic [1:0] error_count;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rtr_vc_flit_type_check #(.num_vcs(4), .min_flits(2), .max_flits(4), .count_width(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .active           (active),
      .flit_valid       (flit_valid),
      .flit_head        (flit_head),
      .flit_tail        (flit_tail),
      .flit_sel_ovc     (flit_sel_ovc),
      .error_clear      (error_clear),
`ifdef RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN
      .error_count      (error_count),
`endif
      .error            (error),
      .error_code       (error_code),
      .error_vc         (error_vc),
      .sticky_error     (sticky_error),
      .first_error_code (first_error_code),
      .first_error_vc   (first_error_vc)
   );

   typedef struct {
      logic       act, v, h, t;
      logic [3:0] sel;
      logic       clr;
      logic       err;
      logic [2:0] code;
      logic [1:0] vc;
      logic [3:0] sticky;
      logic [2:0] fcode;
      logic [1:0] fvc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic act, v, h, t, input logic [3:0] sel, input logic clr,
                               input logic err, input logic [2:0] code, input logic [1:0] vc,
                               input logic [3:0] sticky, input logic [2:0] fcode, input logic [1:0] fvc);
      vec_t x;
      x.act = act; x.v = v; x.h = h; x.t = t; x.sel = sel; x.clr = clr;
      x.err = err; x.code = code; x.vc = vc; x.sticky = sticky; x.fcode = fcode; x.fvc = fvc;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
      end
   endtask

   task automatic step(input vec_t x, input string nm);
      @(negedge clk);
      active = x.act; flit_valid = x.v; flit_head = x.h; flit_tail = x.t;
      flit_sel_ovc = x.sel; error_clear = x.clr;
      #1;
      chk({nm, " comb{err,code,vc}"}, {26'd0, error, error_code, error_vc}, {26'd0, x.err, x.code, x.vc});
      @(posedge clk);
      #1;
      chk({nm, " reg{sticky,fcode,fvc}"}, {23'd0, sticky_error, first_error_code, first_error_vc},
          {23'd0, x.sticky, x.fcode, x.fvc});
   endtask

   initial begin
      // act v h t sel clr | err code vc | sticky fcode fvc
      vecs.push_back(mk(1,1,1,0,4'b0010,0, 0,0,0, 4'b0000,0,0)); // VC1 head
      vecs.push_back(mk(1,1,0,0,4'b0010,0, 0,0,0, 4'b0000,0,0)); // VC1 body
      vecs.push_back(mk(1,1,0,1,4'b0010,0, 0,0,0, 4'b0000,0,0)); // VC1 tail, length 3
      vecs.push_back(mk(1,1,0,0,4'b0010,0, 1,2,1, 4'b0010,2,1)); // VC1 is idle again
      vecs.push_back(mk(1,0,0,0,4'b0000,1, 0,0,0, 4'b0000,0,0)); // clear
      vecs.push_back(mk(1,1,0,0,4'b0001,0, 1,2,0, 4'b0001,2,0)); // VC0 body without head
      vecs.push_back(mk(1,1,1,0,4'b0100,0, 0,0,0, 4'b0001,2,0)); // VC2 head
      vecs.push_back(mk(1,1,1,0,4'b0100,0, 1,3,2, 4'b0101,2,0)); // VC2 head in packet
      vecs.push_back(mk(1,1,0,1,4'b0100,0, 0,0,0, 4'b0101,2,0)); // VC2 tail, length 2
      vecs.push_back(mk(1,0,0,0,4'b0000,1, 0,0,0, 4'b0000,0,0)); // clear
      vecs.push_back(mk(1,1,1,0,4'b1000,0, 0,0,0, 4'b0000,0,0)); // VC3 head
      vecs.push_back(mk(1,1,0,0,4'b1000,0, 0,0,0, 4'b0000,0,0)); // body n=2
      vecs.push_back(mk(1,1,0,0,4'b1000,0, 0,0,0, 4'b0000,0,0)); // body n=3
      vecs.push_back(mk(1,1,0,0,4'b1000,0, 0,0,0, 4'b0000,0,0)); // body n=4
      vecs.push_back(mk(1,1,0,0,4'b1000,0, 1,4,3, 4'b1000,4,3)); // body n=5 LONG
      vecs.push_back(mk(1,1,0,1,4'b1000,0, 0,0,0, 4'b1000,4,3)); // tail, LONG already reported
      vecs.push_back(mk(1,1,1,1,4'b1000,0, 1,5,3, 4'b1000,4,3)); // single flit SHORT
      vecs.push_back(mk(1,0,0,0,4'b0000,1, 0,0,0, 4'b0000,0,0)); // clear
      vecs.push_back(mk(1,1,1,0,4'b0001,0, 0,0,0, 4'b0000,0,0)); // VC0 head
      vecs.push_back(mk(1,1,1,0,4'b0010,0, 0,0,0, 4'b0000,0,0)); // VC1 head
      vecs.push_back(mk(1,1,0,0,4'b0011,0, 1,1,0, 4'b0000,1,0)); // BAD_VC
      vecs.push_back(mk(1,1,0,0,4'b0001,0, 0,0,0, 4'b0000,1,0)); // VC0 body
      vecs.push_back(mk(1,1,0,1,4'b0001,0, 0,0,0, 4'b0000,1,0)); // VC0 tail, length 3
      vecs.push_back(mk(1,1,0,1,4'b0010,0, 0,0,0, 4'b0000,1,0)); // VC1 tail, length 2
      vecs.push_back(mk(1,0,0,0,4'b0011,0, 0,0,0, 4'b0000,1,0)); // invalid flit ignored
      vecs.push_back(mk(1,0,0,0,4'b0000,1, 0,0,0, 4'b0000,0,0)); // clear
      vecs.push_back(mk(1,1,0,0,4'b0001,0, 1,2,0, 4'b0001,2,0)); // VC0 NO_HEAD
      vecs.push_back(mk(1,1,0,0,4'b0100,1, 1,2,2, 4'b0100,2,2)); // clear plus VC2 NO_HEAD
      vecs.push_back(mk(0,1,0,0,4'b0010,0, 1,2,1, 4'b0100,2,2)); // inactive: no capture
      vecs.push_back(mk(0,1,1,0,4'b0100,0, 0,0,0, 4'b0100,2,2)); // inactive head not taken
      vecs.push_back(mk(0,0,0,0,4'b0000,1, 0,0,0, 4'b0100,2,2)); // inactive clear ignored
      vecs.push_back(mk(1,1,0,0,4'b0100,0, 1,2,2, 4'b0100,2,2)); // VC2 still idle
      vecs.push_back(mk(1,0,0,0,4'b0000,1, 0,0,0, 4'b0000,0,0)); // clear
      vecs.push_back(mk(1,1,1,0,4'b0001,0, 0,0,0, 4'b0000,0,0)); // VC0 head
      vecs.push_back(mk(1,1,0,0,4'b0001,0, 0,0,0, 4'b0000,0,0)); // body
      vecs.push_back(mk(1,1,0,0,4'b0001,0, 0,0,0, 4'b0000,0,0)); // body
      vecs.push_back(mk(1,1,0,1,4'b0001,0, 0,0,0, 4'b0000,0,0)); // tail, length 4 = max
      vecs.push_back(mk(1,1,1,0,4'b0010,0, 0,0,0, 4'b0000,0,0)); // VC1 head
      vecs.push_back(mk(1,1,0,0,4'b0010,0, 0,0,0, 4'b0000,0,0)); // body
      vecs.push_back(mk(1,1,0,0,4'b0010,0, 0,0,0, 4'b0000,0,0)); // body
      vecs.push_back(mk(1,1,0,0,4'b0010,0, 0,0,0, 4'b0000,0,0)); // body n=4
      vecs.push_back(mk(1,1,0,1,4'b0010,0, 1,4,1, 4'b0010,4,1)); // tail n=5 LONG

      repeat (2) @(posedge clk);
      #1;
      chk("reset comb{err,code,vc}", {29'd0, error, error_code[1:0]}, 32'd0);
      chk("reset reg{sticky,fcode,fvc}", {23'd0, sticky_error, first_error_code, first_error_vc}, 32'd0);
`ifdef RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN
      chk("reset error_count", {30'd0, error_count}, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

      step(mk(1,1,1,0,4'b0100,0, 0,0,0, 4'b0010,4,1), "pre-reset VC2 head");
      @(negedge clk);
      reset = 1'b0;
      flit_valid = 1'b0;
      #1;
      chk("async reset reg{sticky,fcode,fvc}", {23'd0, sticky_error, first_error_code, first_error_vc}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step(mk(1,1,0,0,4'b0100,0, 1,2,2, 4'b0100,2,2), "post-reset VC2 body");

      step(mk(1,0,0,0,4'b0000,1, 0,0,0, 4'b0000,0,0), "count clear");
`ifdef RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN
      chk("count after clear", {30'd0, error_count}, 32'd0);
`endif
      for (int i = 0; i < 4; i++) begin
         step(mk(1,1,0,0,4'b1000,0, 1,2,3, 4'b1000,2,3), $sformatf("count err%0d", i));
`ifdef RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN
         chk($sformatf("error_count after %0d", i + 1), {30'd0, error_count}, (i < 3) ? i + 1 : 3);
`endif
      end
      step(mk(1,1,0,0,4'b0001,1, 1,2,0, 4'b0001,2,0), "clear plus error");
`ifdef RTR_VC_FLIT_TYPE_CHECK_ERR_COUNT_EN
      chk("error_count clear plus error", {30'd0, error_count}, 32'd1);
`endif

      @(negedge clk);
      flit_valid = 1'b0;
      error_clear = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
